// File: rtl/pi_pkg.sv
// pi_pkg: shared constants, FSM state type and sign-magnitude conversion for the Pi voltage link
package pi_pkg;
   localparam int PI_VOLTAGE_W = 11;
   typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} pi_rx_state_t;
   function automatic logic [PI_VOLTAGE_W-1:0] sm_to_tc(input logic [PI_VOLTAGE_W-1:0] sm);
      logic [PI_VOLTAGE_W-1:0] mag;
      mag = {1'b0, sm[PI_VOLTAGE_W-2:0]};
      return sm[PI_VOLTAGE_W-1] ? -mag : mag;
   endfunction
endpackage

// File: rtl/pi_sync_edge.sv
// pi_sync_edge: multi-flop synchronizer with a change flag against a one-flop-delayed copy
module pi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic toggle
);
   logic [STAGES-1:0] sr;
   logic prev;
   always_ff @(posedge clk) begin
      if (reset) begin
         sr   <= '0;
         prev <= 1'b0;
      end else begin
         sr   <= {sr[STAGES-2:0], d};
         prev <= sr[STAGES-1];
      end
   end
   assign q      = sr[STAGES-1];
   assign toggle = sr[STAGES-1] ^ prev;
endmodule

// File: rtl/pi_voltage_rx.sv
// pi_voltage_rx: oversampled SPI slave receiving sign-magnitude voltage frames.
// Define PI_RX_TWOS_COMP_EN to present voltage as two's complement instead of the raw word.
module pi_voltage_rx
   import pi_pkg::*;
#(
   parameter int VOLTAGE_W   = PI_VOLTAGE_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sclk,
   input  logic                 ncs,
   input  logic                 mosi,
   output logic [VOLTAGE_W-1:0] voltage,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);
   localparam int CW = $clog2(VOLTAGE_W + 2);
   localparam logic [CW-1:0] FULL = CW'(VOLTAGE_W);
   pi_rx_state_t state;
   logic sclk_q, sclk_tog, ncs_q, ncs_tog, sclk_rise, ncs_rise, ncs_fall, eval;
   logic [SYNC_STAGES-1:0] mosi_sr;
   logic [CW-1:0] cnt;
   logic [VOLTAGE_W-1:0] sh, word;
   pi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
      .clk(clk), .reset(reset), .d(sclk), .q(sclk_q), .toggle(sclk_tog)
   );
   pi_sync_edge #(.STAGES(SYNC_STAGES)) u_ncs (
      .clk(clk), .reset(reset), .d(ncs), .q(ncs_q), .toggle(ncs_tog)
   );
   assign sclk_rise = sclk_tog & sclk_q;
   assign ncs_rise  = ncs_tog & ncs_q;
   assign ncs_fall  = ncs_tog & ~ncs_q;
   assign busy      = (state == SHIFT);
`ifdef PI_RX_TWOS_COMP_EN
   assign word = sm_to_tc(sh);
`else
   assign word = sh;
`endif
   // mosi gets the same depth as sclk so the sampled bit lines up with the detected edge
   always_ff @(posedge clk) begin
      if (reset) mosi_sr <= '0;
      else mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
   end
   // eval marks the cycle after ncs rises, so a same-cycle final sclk edge is already counted
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= WAIT_IDLE;
         cnt       <= '0;
         sh        <= '0;
         eval      <= 1'b0;
         voltage   <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid     <= eval && cnt == FULL;
         frame_err <= eval && cnt != FULL;
         if (eval && cnt == FULL) voltage <= word;
         eval <= 1'b0;
         case (state)
            WAIT_IDLE: if (ncs_q) state <= IDLE;
            IDLE: if (ncs_fall) begin
               cnt   <= '0;
               sh    <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               if (sclk_rise) begin
                  sh <= {sh[VOLTAGE_W-2:0], mosi_sr[SYNC_STAGES-1]};
                  if (cnt <= FULL) cnt <= cnt + 1'b1;
               end
               if (ncs_rise) begin
                  state <= IDLE;
                  eval  <= 1'b1;
               end
            end
            default: state <= WAIT_IDLE;
         endcase
      end
   end
endmodule
